// File: rtl/apb_master.sv
// apb_master: turns single command requests into APB transfers.
// One transfer in flight at a time: IDLE -> SETUP -> ACCESS -> IDLE.
// A transfer ends on iPREADY, or is aborted after TIMEOUT consecutive
// wait cycles. Each completion produces a one-cycle oRSP_VALID pulse.
//
// Command handshake: a command is taken on a rising edge where both
// iCMD_VALID and oCMD_READY are high. oCMD_READY is high only in IDLE,
// so the command fields are only looked at on that edge and are free to
// change at any other time.
module apb_master #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              iPCLK,
    input  logic              iPRESET,
    input  logic              iCMD_VALID,
    output logic              oCMD_READY,
    input  logic              iCMD_WRITE,
    input  logic [ADDR_W-1:0] iCMD_ADDR,
    input  logic [31:0]       iCMD_WDATA,
    input  logic [3:0]        iCMD_STRB,
    output logic              oRSP_VALID,
    output logic [31:0]       oRSP_RDATA,
    output logic              oRSP_SLVERR,
    output logic              oRSP_TIMEOUT,
    output logic              oPSEL,
    output logic              oPENABLE,
    output logic              oPWRITE,
    output logic [ADDR_W-1:0] oPADDR,
    output logic [31:0]       oPWDATA,
    output logic [3:0]        oPSTRB,
    input  logic [31:0]       iPRDATA,
    input  logic              iPREADY,
    input  logic              iPSLVERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // Wait count at which the next stalled ACCESS cycle aborts the transfer.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic [3:0]        pstrb_q, pstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_slverr_q, rsp_slverr_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    // Next-state and registered-output values; everything holds by default.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (iCMD_VALID) begin
                    state_d   = S_SETUP;
                    cnt_d     = 8'd0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = iCMD_WRITE;
                    paddr_d   = iCMD_ADDR;
                    pwdata_d  = iCMD_WDATA;
                    pstrb_d   = iCMD_WRITE ? iCMD_STRB : 4'b0000;
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                if (iPREADY) begin
                    // Ready wins even on the edge that would have timed out.
                    state_d       = S_IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = iPSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !iPSLVERR) ? iPRDATA : 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST_WAIT) begin
                        state_d       = S_IDLE;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_valid_d   = 1'b1;
                        rsp_slverr_d  = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_rdata_d   = 32'h0;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iPCLK) begin
        if (iPRESET) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= 32'h0;
            pstrb_q       <= 4'b0000;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign oCMD_READY   = (state_q == S_IDLE);
    assign oPSEL        = psel_q;
    assign oPENABLE     = penable_q;
    assign oPWRITE      = pwrite_q;
    assign oPADDR       = paddr_q;
    assign oPWDATA      = pwdata_q;
    assign oPSTRB       = pstrb_q;
    assign oRSP_VALID   = rsp_valid_q;
    assign oRSP_RDATA   = rsp_rdata_q;
    assign oRSP_SLVERR  = rsp_slverr_q;
    assign oRSP_TIMEOUT = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a small APB slave model with programmable wait
// states and error behaviour, a command driver, and a response scoreboard.
module tb_apb_master;

    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr  = '0;
    logic [31:0]       cmd_wdata = 32'h0;
    logic [3:0]        cmd_strb  = 4'h0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_slverr;
    logic              rsp_timeout;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [31:0]       prdata  = 32'h0;
    logic              pready  = 1'b0;
    logic              pslverr = 1'b0;

    apb_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .iPCLK       (clk),
        .iPRESET     (rst),
        .iCMD_VALID  (cmd_valid),
        .oCMD_READY  (cmd_ready),
        .iCMD_WRITE  (cmd_write),
        .iCMD_ADDR   (cmd_addr),
        .iCMD_WDATA  (cmd_wdata),
        .iCMD_STRB   (cmd_strb),
        .oRSP_VALID  (rsp_valid),
        .oRSP_RDATA  (rsp_rdata),
        .oRSP_SLVERR (rsp_slverr),
        .oRSP_TIMEOUT(rsp_timeout),
        .oPSEL       (psel),
        .oPENABLE    (penable),
        .oPWRITE     (pwrite),
        .oPADDR      (paddr),
        .oPWDATA     (pwdata),
        .oPSTRB      (pstrb),
        .iPRDATA     (prdata),
        .iPREADY     (pready),
        .iPSLVERR    (pslverr)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard entry: {latency[7:0], timeout, slverr, rdata[31:0]}
    logic [41:0] exp_q[$];

    int                cyc        = 0;
    int                accept_cyc = 0;
    logic              cur_write  = 1'b0;
    logic [ADDR_W-1:0] cur_addr   = '0;
    logic [31:0]       cur_wdata  = 32'h0;
    logic [3:0]        cur_strb   = 4'h0;
    bit                prev_psel  = 1'b0;

    // Slave model configuration.
    int          slv_wait  = 0;
    logic [31:0] slv_rdata = 32'h0;
    bit          err_ready = 1'b0;
    bit          err_wait  = 1'b0;
    int          acc_cnt   = 0;

    // Monitor + slave model, both on the falling edge.
    always @(negedge clk) begin
        logic [41:0] e;
        cyc++;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata",   64'(rsp_rdata),   64'(e[31:0]));
                check("rsp_slverr",  64'(rsp_slverr),  64'(e[32]));
                check("rsp_timeout", 64'(rsp_timeout), 64'(e[33]));
                check("rsp_latency", 64'(cyc - accept_cyc), 64'(e[41:34]));
            end
        end
        if (psel && !rst) begin
            check("penable_phase", 64'(penable), 64'(prev_psel));
            check("pwrite_hold",   64'(pwrite),  64'(cur_write));
            check("paddr_hold",    64'(paddr),   64'(cur_addr));
            check("pstrb_hold",    64'(pstrb),   64'(cur_strb));
            if (cur_write) check("pwdata_hold", 64'(pwdata), 64'(cur_wdata));
        end
        prev_psel = psel;

        if (psel && penable) begin
            pready  = (acc_cnt >= slv_wait);
            pslverr = pready ? err_ready : err_wait;
            prdata  = pready ? slv_rdata : $urandom();
            acc_cnt++;
        end else begin
            pready  = 1'b0;
            pslverr = err_wait;
            prdata  = $urandom();
            acc_cnt = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_xfer(input bit w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit push, input logic [31:0] e_rdata,
                           input bit e_err, input bit e_to, input int e_lat);
        int t;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        cur_write  = w;
        cur_addr   = a;
        cur_wdata  = d;
        cur_strb   = w ? s : 4'h0;
        if (push) exp_q.push_back({8'(e_lat), e_to, e_err, e_rdata});
        // Scramble the command bus while the transfer is in flight.
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom());
        cmd_addr  = ADDR_W'($urandom());
        cmd_wdata = $urandom();
        cmd_strb  = 4'($urandom());
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"},   64'(cmd_ready),   64'd1);
        check({tag, "_psel"},        64'(psel),        64'd0);
        check({tag, "_penable"},     64'(penable),     64'd0);
        check({tag, "_pwrite"},      64'(pwrite),      64'd0);
        check({tag, "_paddr"},       64'(paddr),       64'd0);
        check({tag, "_pwdata"},      64'(pwdata),      64'd0);
        check({tag, "_pstrb"},       64'(pstrb),       64'd0);
        check({tag, "_rsp_valid"},   64'(rsp_valid),   64'd0);
        check({tag, "_rsp_rdata"},   64'(rsp_rdata),   64'd0);
        check({tag, "_rsp_slverr"},  64'(rsp_slverr),  64'd0);
        check({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        int wn;
        bit w;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic write and read, zero wait states.
        slv_wait = 0;
        do_xfer(1'b1, 16'h0004, 32'hA5A5_1234, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0, 3);
        wait_drain();
        slv_rdata = 32'hDEAD_BEEF;
        do_xfer(1'b0, 16'h0000, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 3);
        wait_drain();

        // Three wait states.
        slv_wait = 3;
        slv_rdata = 32'h1357_9BDF;
        do_xfer(1'b0, 16'h1230, 32'h0, 4'h0, 1'b1, 32'h1357_9BDF, 1'b0, 1'b0, 6);
        wait_drain();

        // Slave never ready: abort after TIMEOUT wait cycles.
        slv_wait = 255;
        do_xfer(1'b0, 16'h0BAD, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 1'b1, TIMEOUT + 2);
        wait_drain();
        do_xfer(1'b1, 16'h0BAE, 32'h0102_0304, 4'h5, 1'b1, 32'h0, 1'b1, 1'b1, TIMEOUT + 2);
        wait_drain();

        // Ready on the very edge that would time out: normal completion.
        slv_wait = TIMEOUT - 1;
        slv_rdata = 32'hCAFE_F00D;
        do_xfer(1'b0, 16'h0040, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, TIMEOUT + 2);
        wait_drain();

        // Slave error at completion.
        slv_wait = 0;
        err_ready = 1'b1;
        do_xfer(1'b1, 16'h0008, 32'h5555_AAAA, 4'h3, 1'b1, 32'h0, 1'b1, 1'b0, 3);
        wait_drain();
        slv_rdata = 32'h7777_7777;
        do_xfer(1'b0, 16'h000C, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 1'b0, 3);
        wait_drain();

        // Slave error only while waiting: ignored.
        err_ready = 1'b0;
        err_wait = 1'b1;
        slv_wait = 2;
        slv_rdata = 32'h2468_ACE0;
        do_xfer(1'b0, 16'h0010, 32'h0, 4'h0, 1'b1, 32'h2468_ACE0, 1'b0, 1'b0, 5);
        wait_drain();
        err_wait = 1'b0;

        // Back-to-back transfers: one every three cycles.
        slv_wait = 0;
        slv_rdata = 32'h0F0F_0F0F;
        do_xfer(1'b1, 16'h0100, 32'h1111_1111, 4'h1, 1'b1, 32'h0, 1'b0, 1'b0, 3);
        do_xfer(1'b0, 16'h0104, 32'h0, 4'h0, 1'b1, 32'h0F0F_0F0F, 1'b0, 1'b0, 3);
        check("b2b_spacing", 64'(cyc - accept_cyc), 64'd0);
        do_xfer(1'b1, 16'h0108, 32'h2222_2222, 4'hC, 1'b1, 32'h0, 1'b0, 1'b0, 3);
        wait_drain();

        // Random transfers with random wait states.
        for (int i = 0; i < 8; i++) begin
            wn = $urandom_range(0, 5);
            w = 1'($urandom_range(0, 1));
            r = $urandom();
            slv_wait = wn;
            slv_rdata = r;
            do_xfer(w, ADDR_W'($urandom()), $urandom(), 4'($urandom()), 1'b1,
                    w ? 32'h0 : r, 1'b0, 1'b0, 3 + wn);
            wait_drain();
        end

        // Reset in the middle of ACCESS: no response, outputs to reset values.
        slv_wait = 255;
        do_xfer(1'b1, 16'h0ABC, 32'hFFFF_0000, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("mid_access_penable", 64'(penable), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_no_rsp", 64'(rsp_valid), 64'd0);

        // New command after reset release.
        slv_wait = 1;
        slv_rdata = 32'h600D_600D;
        do_xfer(1'b0, 16'h0020, 32'h0, 4'h0, 1'b1, 32'h600D_600D, 1'b0, 1'b0, 4);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop if something hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
